// File: rtl/incr_pkg.sv
// incr_pkg: shared mode enum and width limit for the incrementer family
package incr_pkg;
    typedef enum logic {MODE_WRAP, MODE_SAT} incr_mode_e;
    localparam int MAX_WIDTH = 32;
endpackage

// File: rtl/incr_nbits.sv
// incr_nbits: combinational N-bit ripple incrementer, carry-out flags all-ones input
module incr_nbits #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] incrA,
    output logic             cout
);
    assign incrA[0] = ~A[0];
    for (genvar i = 1; i < WIDTH; i++) begin : g_bit
        assign incrA[i] = A[i] ^ (&A[i-1:0]);
    end
    assign cout = &A;
endmodule

// File: rtl/incr_counter.sv
// incr_counter: registered up/down wrap/saturate counter on incr_nbits; INCR_COUNTER_STICKY_EN adds sticky_err
module incr_counter
    import incr_pkg::*;
#(
    parameter int             WIDTH   = 8,
    parameter incr_mode_e     MODE    = MODE_WRAP,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef INCR_COUNTER_STICKY_EN
    input  logic             clr_sticky,
    output logic             sticky_err,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("incr_counter: WIDTH out of range");
    end
    logic [WIDTH-1:0] a, s, step, count_n;
    logic             c, step_en, ovf_n, unf_n;
    // decrement reuses the incrementer: count-1 == ~incr(~count)
    assign a    = up_dn ? count : ~count;
    assign step = up_dn ? s : ~s;
    incr_nbits #(.WIDTH(WIDTH)) u_incr (.A(a), .incrA(s), .cout(c));
    assign tc = c;
    always_comb begin
        step_en = en & ~load;
        ovf_n   = step_en & c & up_dn;
        unf_n   = step_en & c & ~up_dn;
        count_n = load ? load_val : !en ? count : (c && MODE == MODE_SAT) ? count : step;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= count_n;
            ovf   <= ovf_n;
            unf   <= unf_n;
        end
    end
`ifdef INCR_COUNTER_STICKY_EN
    always_ff @(posedge clk) begin
        if (rst) sticky_err <= 1'b0;
        else     sticky_err <= ovf_n | unf_n | (sticky_err & ~clr_sticky);
    end
`endif
endmodule

// File: tb/tb_incr_counter.sv
// tb_incr_counter: directed self-checking bench for incr_counter and incr_nbits
module tb_incr_counter;
    import incr_pkg::*;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, up_dn = 1'b1, load = 1'b0, clr_sticky = 1'b0;
    logic [2:0] load_val3 = '0, c3w, c3s, a3, i3;
    logic [7:0] load_val8 = '0, c8, a8, i8;
    logic tc3w, ovf3w, unf3w, tc3s, ovf3s, unf3s, tc8, ovf8, unf8, co3, co8;
    logic st3w, st3s, st8;
    int total = 0, bad = 0;
    always #5 clk = ~clk;

    incr_counter #(.WIDTH(3), .MODE(MODE_WRAP)) u_w3 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val3),
`ifdef INCR_COUNTER_STICKY_EN
        .clr_sticky(clr_sticky), .sticky_err(st3w),
`endif
        .count(c3w), .tc(tc3w), .ovf(ovf3w), .unf(unf3w));
    incr_counter #(.WIDTH(3), .MODE(MODE_SAT)) u_s3 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val3),
`ifdef INCR_COUNTER_STICKY_EN
        .clr_sticky(clr_sticky), .sticky_err(st3s),
`endif
        .count(c3s), .tc(tc3s), .ovf(ovf3s), .unf(unf3s));
    incr_counter #(.WIDTH(8), .MODE(MODE_WRAP), .RST_VAL(8'h10)) u_w8 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val8),
`ifdef INCR_COUNTER_STICKY_EN
        .clr_sticky(clr_sticky), .sticky_err(st8),
`endif
        .count(c8), .tc(tc8), .ovf(ovf8), .unf(unf8));
    incr_nbits #(.WIDTH(3)) u_n3 (.A(a3), .incrA(i3), .cout(co3));
    incr_nbits #(.WIDTH(8)) u_n8 (.A(a8), .incrA(i8), .cout(co8));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; en = 1'b1; load_val3 = 3'd5; load_val8 = 8'h77;
        step();
        total++;
        if (c3w !== 3'd0 || c3s !== 3'd0 || c8 !== 8'h10) begin
            bad++; $display("FAIL reset_count: got %0d %0d %h want 0 0 10", c3w, c3s, c8);
        end
        total++;
        if ({ovf3w, unf3w, ovf3s, unf3s, ovf8, unf8} !== 6'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 000000", {ovf3w, unf3w, ovf3s, unf3s, ovf8, unf8});
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_wrap3();
        logic [2:0] exp;
        rst = 1'b1; step(); rst = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp = 3'(k % 8);
            total++;
            if (c3w !== exp || ovf3w !== (k == 8) || unf3w !== 1'b0 || tc3w !== (exp == 3'd7)) begin
                bad++; $display("FAIL wrap3_edge%0d: got c=%0d ovf=%b unf=%b tc=%b want c=%0d ovf=%b tc=%b",
                    k, c3w, ovf3w, unf3w, tc3w, exp, k == 8, exp == 3'd7);
            end
        end
        up_dn = 1'b0;
        step();
        total++;
        if (c3w !== 3'd0 || unf3w !== 1'b0 || tc3w !== 1'b1) begin
            bad++; $display("FAIL dir_change: got c=%0d unf=%b tc=%b want 0 0 1", c3w, unf3w, tc3w);
        end
        step();
        total++;
        if (c3w !== 3'd7 || unf3w !== 1'b1 || ovf3w !== 1'b0) begin
            bad++; $display("FAIL wrap3_under: got c=%0d unf=%b ovf=%b want 7 1 0", c3w, unf3w, ovf3w);
        end
        en = 1'b0;
        step();
        total++;
        if (c3w !== 3'd7 || unf3w !== 1'b0) begin
            bad++; $display("FAIL hold: got c=%0d unf=%b want 7 0", c3w, unf3w);
        end
    endtask

    task automatic test_sat3();
        load_val3 = 3'd6; load = 1'b1; en = 1'b0; up_dn = 1'b1;
        step();
        total++;
        if (c3s !== 3'd6) begin bad++; $display("FAIL sat3_load: got %0d want 6", c3s); end
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            total++;
            if (c3s !== 3'd7 || ovf3s !== (k >= 2)) begin
                bad++; $display("FAIL sat3_edge%0d: got c=%0d ovf=%b want 7 %b", k, c3s, ovf3s, k >= 2);
            end
        end
        load = 1'b1;
        step();
        total++;
        if (c3s !== 3'd6 || ovf3s !== 1'b0) begin
            bad++; $display("FAIL sat3_reload: got c=%0d ovf=%b want 6 0", c3s, ovf3s);
        end
        load_val3 = 3'd0; up_dn = 1'b0;
        step();
        load = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            step();
            total++;
            if (c3s !== 3'd0 || unf3s !== 1'b1) begin
                bad++; $display("FAIL sat3_under%0d: got c=%0d unf=%b want 0 1", k, c3s, unf3s);
            end
        end
        en = 1'b0; up_dn = 1'b1;
    endtask

    task automatic test_down8();
        logic [7:0] exp [3] = '{8'h00, 8'hFF, 8'hFE};
        logic       eu  [3] = '{1'b0, 1'b1, 1'b0};
        logic       et  [3] = '{1'b1, 1'b0, 1'b0};
        load_val8 = 8'h01; load = 1'b1; en = 1'b0;
        step();
        load = 1'b0; up_dn = 1'b0; en = 1'b1;
        #1;
        total++;
        if (tc8 !== 1'b0) begin bad++; $display("FAIL down8_tc0: got %b want 0", tc8); end
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (c8 !== exp[k] || unf8 !== eu[k] || tc8 !== et[k] || ovf8 !== 1'b0) begin
                bad++; $display("FAIL down8_edge%0d: got c=%h unf=%b tc=%b ovf=%b want c=%h unf=%b tc=%b",
                    k, c8, unf8, tc8, ovf8, exp[k], eu[k], et[k]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_tc();
        load_val8 = 8'hFF; load = 1'b1;
        step();
        load = 1'b0; up_dn = 1'b1;
        #1;
        total++;
        if (tc8 !== 1'b1) begin bad++; $display("FAIL tc_up_ff: got %b want 1", tc8); end
        up_dn = 1'b0;
        #1;
        total++;
        if (tc8 !== 1'b0) begin bad++; $display("FAIL tc_dn_ff: got %b want 0", tc8); end
    endtask

    task automatic test_load_en();
        rst = 1'b1; step(); rst = 1'b0;
        load_val8 = 8'h5A; load = 1'b1; en = 1'b1; up_dn = 1'b1;
        step();
        total++;
        if (c8 !== 8'h5A || ovf8 !== 1'b0 || unf8 !== 1'b0) begin
            bad++; $display("FAIL load_wins: got c=%h ovf=%b unf=%b want 5a 0 0", c8, ovf8, unf8);
        end
        load = 1'b0;
        step();
        total++;
        if (c8 !== 8'h5B) begin bad++; $display("FAIL step_after_load: got %h want 5b", c8); end
        rst = 1'b1; load = 1'b1;
        step();
        total++;
        if (c8 !== 8'h10) begin bad++; $display("FAIL rst_over_load: got %h want 10", c8); end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_incr();
        for (int v = 0; v < 8; v++) begin
            a3 = 3'(v);
            #1;
            total++;
            if (i3 !== 3'((v + 1) % 8) || co3 !== (v == 7)) begin
                bad++; $display("FAIL incr3_%0d: got %0d/%b want %0d/%b", v, i3, co3, (v + 1) % 8, v == 7);
            end
        end
        for (int v = 0; v < 256; v++) begin
            a8 = 8'(v);
            #1;
            total++;
            if (i8 !== 8'((v + 1) % 256) || co8 !== (v == 255)) begin
                bad++; $display("FAIL incr8_%0d: got %0d/%b want %0d/%b", v, i8, co8, (v + 1) % 256, v == 255);
            end
        end
    endtask

`ifdef INCR_COUNTER_STICKY_EN
    task automatic test_sticky();
        rst = 1'b1; step(); rst = 1'b0;
        total++;
        if (st3w !== 1'b0) begin bad++; $display("FAIL sticky_rst: got %b want 0", st3w); end
        en = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 8; k++) step();
        total++;
        if (c3w !== 3'd0 || ovf3w !== 1'b1 || st3w !== 1'b1) begin
            bad++; $display("FAIL sticky_set: got c=%0d ovf=%b st=%b want 0 1 1", c3w, ovf3w, st3w);
        end
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (st3w !== 1'b1) begin bad++; $display("FAIL sticky_hold%0d: got %b want 1", k, st3w); end
        end
        clr_sticky = 1'b1;
        step();
        total++;
        if (st3w !== 1'b0) begin bad++; $display("FAIL sticky_clr: got %b want 0", st3w); end
        clr_sticky = 1'b0; load_val3 = 3'd7; load = 1'b1;
        step();
        load = 1'b0; en = 1'b1; clr_sticky = 1'b1;
        step();
        total++;
        if (ovf3w !== 1'b1 || st3w !== 1'b1) begin
            bad++; $display("FAIL sticky_set_wins: got ovf=%b st=%b want 1 1", ovf3w, st3w);
        end
        en = 1'b0;
        step();
        total++;
        if (st3w !== 1'b0) begin bad++; $display("FAIL sticky_clr2: got %b want 0", st3w); end
        clr_sticky = 1'b0;
    endtask
`endif

    initial begin
        a3 = '0; a8 = '0;
        test_reset();
        test_wrap3();
        test_sat3();
        test_down8();
        test_tc();
        test_load_en();
        test_incr();
`ifdef INCR_COUNTER_STICKY_EN
        test_sticky();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/incr_counter.md
Name: incr_counter

Overview:
- Registered, parametrised up/down counter built on a generalised N-bit ripple incrementer.
- Successor to the fixed-width combinational incrementers; adds:
  - arbitrary width
  - direction control
  - synchronous load
  - wrap or saturate mode
  - terminal-count and overflow/underflow reporting
- Used as the general event/address counter in adder-family datapaths and testbenches.

Parameters:
- WIDTH, 8: counter width in bits; legal range 2..32.
- MODE, incr_pkg::MODE_WRAP: MODE_WRAP rolls over at the range limits; MODE_SAT holds at the range limits.
- RST_VAL, 0: value loaded into count on reset; must fit in WIDTH bits.

Ports:
- clk  input  1  single clock for the block; all state updates on its rising edge.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- en  input  1  count enable; one step per clock while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value captured when load=1.
- count  output  WIDTH  registered counter value.
- tc  output  1  terminal count (combinational from count and up_dn).
- ovf  output  1  registered pulse: increment attempted at all-ones.
- unf  output  1  registered pulse: decrement attempted at zero.

Behaviour:
- Reset values (rst=1 at a rising edge):
  - count = RST_VAL
  - ovf = 0
  - unf = 0
  - rst overrides load and en in the same cycle.
- Priority per edge: rst > load > en.
  - Neither load nor en asserted: count holds; ovf = unf = 0.
- Load:
  - count <= load_val.
  - ovf and unf are 0 in the following cycle.
  - No boundary detection on loaded values.
- Count (en=1, load=0), up_dn=1:
  - count <= count + 1, computed by incr_nbits.
  - At all-ones in MODE_WRAP: count <= 0; ovf=1 for one cycle.
  - At all-ones in MODE_SAT: count holds at all-ones; ovf=1 for one cycle, repeating on every further enabled cycle.
- Count (en=1, load=0), up_dn=0:
  - count <= count - 1, computed as ~incr(~count), sharing the same incrementer.
  - At zero in MODE_WRAP: count <= all-ones; unf=1 for one cycle.
  - At zero in MODE_SAT: count holds at 0; unf=1 for one cycle, repeating on every further enabled cycle.
- Latency:
  - count reflects an enabled step one edge after en is sampled.
  - ovf/unf are asserted in the same cycle the resulting count appears.
- tc:
  - up_dn=1: tc = (count == all-ones).
  - up_dn=0: tc = (count == 0).
  - Purely combinational; changes immediately when up_dn toggles.
- Direction change: up_dn toggling while en=1 takes effect at the next edge; no dead cycle.
- Simultaneous load and en: load wins; no step is taken.
- Reset mid-count: the next edge forces RST_VAL and clears ovf/unf; a pending pulse is dropped.
- Arithmetic rules:
  - All arithmetic is unsigned, modulo 2^WIDTH.
  - incr_nbits carry-out (all-ones input) is the sole overflow detector.
  - Underflow is detected via incr_nbits carry-out on ~count.
- No X propagation: every output has a defined value from the first edge with rst=1.

Optional Feature:
- Macro: INCR_COUNTER_STICKY_EN.
- When defined:
  - Adds input clr_sticky (1 bit) and output sticky_err (1 bit).
  - sticky_err sets on any cycle ovf or unf is asserted and remains set.
  - Cleared by rst or clr_sticky=1; if clr_sticky and a new event coincide, set wins.
  - sticky_err resets to 0.
- When undefined: no extra ports or logic; the port list is exactly as above.

Decomposition:
- Package incr_pkg:
  - typedef enum logic {MODE_WRAP, MODE_SAT} incr_mode_e
  - localparam MAX_WIDTH = 32
- Sub-module incr_nbits #(WIDTH): combinational ripple incrementer.
  - Inputs: A[WIDTH].
  - Outputs: incrA[WIDTH], cout.
  - Bit i = A[i] ^ &A[i-1:0]; bit 0 = ~A[0].
  - Generalises the 3-bit XOR/AND chain; cout = &A.
- incr_counter instantiates one incr_nbits, with its input muxed between count and ~count by up_dn.

Test Plan:
- WIDTH=3, MODE_WRAP, rst then en=1, up_dn=1 for 9 edges -> count 0,1,...,7,0,1; ovf=1 only in the cycle count returns to 0; tc=1 while count=7.
- WIDTH=3, MODE_SAT, load_val=6 then en=1, up_dn=1 for 4 edges -> count 7,7,7,7; ovf=1 on edges 2, 3 and 4; count never wraps.
- WIDTH=8, MODE_WRAP, load 0x01, then down 3 edges -> count 0x00, 0xFF, 0xFE; unf=1 only with 0xFF; tc=1 while count=0x00 with up_dn=0.
- WIDTH=8, load=1 and en=1 together with load_val=0x5A, count=0x10 -> count=0x5A next edge, no step, ovf=unf=0; rst asserted with load=1 -> count=RST_VAL.
- Exhaustive incr_nbits check, WIDTH=3 and WIDTH=8, all inputs -> incrA == (A+1) mod 2^WIDTH, cout == (A == all-ones).
- With INCR_COUNTER_STICKY_EN, WIDTH=3, MODE_WRAP, count to wrap -> sticky_err=1 stays high for 10 further cycles; clr_sticky=1 -> 0 next edge; clr_sticky coincident with ovf -> stays 1.
